// File: rtl/mlp_feeder.sv
// Host-side feeder for the MLP stream: issues VECTOR_LEN words as spaced strobes,
// buffers MLP results in a FIFO and reports completion, overflow and done timeout.
module mlp_feeder #(
  parameter int DATA_WIDTH   = 32,
  parameter int OUTPUT_WIDTH = 32,
  parameter int VECTOR_LEN   = 16,
  parameter int ISSUE_GAP    = 1,
  parameter int RES_DEPTH    = 8,
  parameter int TIMEOUT      = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   mlp_data,
  output logic                    mlp_new_data,
  input  logic                    mlp_output_ready,
  input  logic [OUTPUT_WIDTH-1:0] mlp_output,
  input  logic                    mlp_done,
  output logic [OUTPUT_WIDTH-1:0] res_data,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              error
);

  localparam int CW  = $clog2(VECTOR_LEN + 1);
  localparam int GW  = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int AW  = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int OCW = AW + 1;

  localparam logic [CW-1:0]  LEN_C      = CW'(VECTOR_LEN);
  localparam logic [CW-1:0]  LAST_C     = CW'(VECTOR_LEN - 1);
  localparam logic [GW-1:0]  GAP_RELOAD = GW'(ISSUE_GAP - 1);
  localparam logic [TW-1:0]  TO_LAST    = TW'(TIMEOUT - 1);
  localparam logic [OCW-1:0] DEPTH_C    = OCW'(RES_DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, FLUSH} state_t;

  state_t                  state_q;
  logic [CW-1:0]           count_q;
  logic [GW-1:0]           gap_q;
  logic [TW-1:0]           to_q;
  logic [DATA_WIDTH-1:0]   mlp_data_q;
  logic                    new_q;
  logic                    done_q;
  logic [1:0]              error_q;

  logic [OUTPUT_WIDTH-1:0] mem_q [RES_DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [OCW-1:0]          occ_q, occ_d;

  logic accept, capture, fifo_empty, fifo_full, pop, push, overflow;

  assign in_ready   = (state_q == SEND) && (gap_q == '0) && (count_q < LEN_C);
  assign accept     = in_ready && in_valid;
  assign capture    = (state_q != IDLE) && mlp_output_ready;
  assign fifo_empty = (occ_q == '0);
  assign fifo_full  = (occ_q == DEPTH_C);
  assign pop        = !fifo_empty && res_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push       = capture && (!fifo_full || pop);
  assign overflow   = capture && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      gap_q      <= '0;
      to_q       <= '0;
      mlp_data_q <= '0;
      new_q      <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= '0;
    end else begin
      new_q  <= accept;
      done_q <= 1'b0;
      if (accept) mlp_data_q <= in_data;
      if (overflow) error_q[0] <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SEND;
            count_q <= '0;
            gap_q   <= '0;
            error_q <= '0;
          end
        end
        SEND: begin
          if (accept) begin
            count_q <= count_q + 1'b1;
            gap_q   <= GAP_RELOAD;
            if (count_q == LAST_C) begin
              state_q <= WAIT_DONE;
              to_q    <= '0;
            end
          end else if (gap_q != '0) begin
            gap_q <= gap_q - 1'b1;
          end
        end
        WAIT_DONE: begin
          if (mlp_done) begin
            state_q <= FLUSH;
          end else if (to_q == TO_LAST) begin
            error_q[1] <= 1'b1;
            state_q    <= FLUSH;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        FLUSH: begin
          if (fifo_empty) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= mlp_output;
  end

  assign res_data     = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign res_valid    = !fifo_empty;
  assign mlp_data     = mlp_data_q;
  assign mlp_new_data = new_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_mlp_feeder.sv
// Directed bench for mlp_feeder: dutA (VECTOR_LEN=4, ISSUE_GAP=1, TIMEOUT=16) covers
// the main flow, FIFO and error paths; dutB (ISSUE_GAP=3) covers strobe spacing.
module tb_mlp_feeder;

  localparam int DW = 32;
  localparam int OW = 32;

  typedef struct {
    int st; int iv; int id; int mor; int mo; int md; int rr;
    int eInReady; int eNew; int eData; int eBusy; int eDone; int eResValid; int eRes; int eErr;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          inValid = 1'b0;
  logic [DW-1:0] inData = '0;
  logic          outReady = 1'b0;
  logic [OW-1:0] mlpOut = '0;
  logic          mlpDone = 1'b0;
  logic          resReady = 1'b0;

  logic          aInReady, aNew, aResValid, aBusy, aDone;
  logic [DW-1:0] aData;
  logic [OW-1:0] aRes;
  logic [1:0]    aErr;
  logic          bInReady, bNew, bResValid, bBusy, bDone;
  logic [DW-1:0] bData;
  logic [OW-1:0] bRes;
  logic [1:0]    bErr;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs [13];

  mlp_feeder #(.DATA_WIDTH(DW), .OUTPUT_WIDTH(OW), .VECTOR_LEN(4), .ISSUE_GAP(1),
               .RES_DEPTH(8), .TIMEOUT(16)) dutA (
    .clk(clk), .rst(rst), .start(start), .in_data(inData), .in_valid(inValid),
    .in_ready(aInReady), .mlp_data(aData), .mlp_new_data(aNew),
    .mlp_output_ready(outReady), .mlp_output(mlpOut), .mlp_done(mlpDone),
    .res_data(aRes), .res_valid(aResValid), .res_ready(resReady),
    .busy(aBusy), .done(aDone), .error(aErr));

  mlp_feeder #(.DATA_WIDTH(DW), .OUTPUT_WIDTH(OW), .VECTOR_LEN(4), .ISSUE_GAP(3),
               .RES_DEPTH(8), .TIMEOUT(1024)) dutB (
    .clk(clk), .rst(rst), .start(start), .in_data(inData), .in_valid(inValid),
    .in_ready(bInReady), .mlp_data(bData), .mlp_new_data(bNew),
    .mlp_output_ready(outReady), .mlp_output(mlpOut), .mlp_done(mlpDone),
    .res_data(bRes), .res_valid(bResValid), .res_ready(resReady),
    .busy(bBusy), .done(bDone), .error(bErr));

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkTrue(input string name, input bit cond, input int act, input int req);
    checks++;
    if (!cond) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required at least %0d", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic iv, input logic [31:0] id,
                               input logic mor, input logic [31:0] mo,
                               input logic md, input logic rr);
    start = s; inValid = iv; inData = id;
    outReady = mor; mlpOut = mo; mlpDone = md; resReady = rr;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Each row is one clock cycle: inputs sampled at the closing edge, outputs seen during it.
  task automatic runTable(input string tag);
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].st[0], vecs[i].iv[0], vecs[i].id, vecs[i].mor[0],
                    vecs[i].mo, vecs[i].md[0], vecs[i].rr[0]);
      checkOutput($sformatf("%s[%0d] inReady", tag, i), 32'(aInReady), vecs[i].eInReady);
      checkOutput($sformatf("%s[%0d] newData", tag, i), 32'(aNew), vecs[i].eNew);
      checkOutput($sformatf("%s[%0d] mlpData", tag, i), aData, vecs[i].eData);
      checkOutput($sformatf("%s[%0d] busy", tag, i), 32'(aBusy), vecs[i].eBusy);
      checkOutput($sformatf("%s[%0d] done", tag, i), 32'(aDone), vecs[i].eDone);
      checkOutput($sformatf("%s[%0d] resValid", tag, i), 32'(aResValid), vecs[i].eResValid);
      checkOutput($sformatf("%s[%0d] resData", tag, i), aRes, vecs[i].eRes);
      checkOutput($sformatf("%s[%0d] error", tag, i), 32'(aErr), vecs[i].eErr);
      @(negedge clk);
    end
    idleInputs();
  endtask

  task automatic startCmd();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    idleInputs();
  endtask

  task automatic feedWords(input int n, input logic [31:0] base);
    int   idx = 0;
    int   guard = 0;
    logic ready;
    while (idx < n && guard < 50) begin
      ready   = aInReady;
      inValid = 1'b1;
      inData  = base + idx;
      @(negedge clk);
      if (ready) idx++;
      guard++;
    end
    idleInputs();
    checkOutput("feedCount", idx, n);
  endtask

  task automatic gapRun(input bit randomValid);
    int   idx = 0;
    int   cyc = 0;
    int   strobes = 0;
    int   lastStrobe = 0;
    int   readyCnt = 0;
    logic ready;
    while (strobes < 4 && cyc < 400) begin
      if (bNew) begin
        checkOutput($sformatf("gapData%0d", strobes), bData, 32'h500 + strobes);
        if (strobes > 0) begin
          if (randomValid) checkTrue("gapSpacingMin", (cyc - lastStrobe) >= 3, cyc - lastStrobe, 3);
          else checkOutput("gapSpacing", cyc - lastStrobe, 3);
        end
        lastStrobe = cyc;
        strobes++;
      end
      ready = bInReady;
      if (ready) readyCnt++;
      inValid = randomValid ? 1'($urandom_range(0, 1)) : 1'b1;
      inData  = 32'h500 + idx;
      @(negedge clk);
      if (ready && inValid) idx++;
      cyc++;
    end
    idleInputs();
    checkOutput("gapStrobes", strobes, 4);
    if (!randomValid) checkOutput("gapReadyCycles", readyCnt, 4);
  endtask

  task automatic finishB();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    idleInputs();
    @(negedge clk);
    checkOutput("gapEndBusy", 32'(bBusy), 0);
    checkOutput("gapEndDone", 32'(bDone), 1);
    checkOutput("gapEndError", 32'(bErr), 0);
  endtask

  initial begin
    int            cyc;
    logic [31:0]   expPop [8];

    //            st iv id   mor mo    md rr | inR new data busy done rv res   err
    vecs[0]  = '{1, 0, 0,   0,  0,    0, 0,   0,  0,  0,   0,   0,   0, 0,    0};
    vecs[1]  = '{0, 1, 1,   0,  0,    0, 0,   1,  0,  0,   1,   0,   0, 0,    0};
    vecs[2]  = '{0, 1, 2,   0,  0,    0, 0,   1,  1,  1,   1,   0,   0, 0,    0};
    vecs[3]  = '{0, 1, 3,   0,  0,    0, 0,   1,  1,  2,   1,   0,   0, 0,    0};
    vecs[4]  = '{0, 1, 4,   0,  0,    0, 0,   1,  1,  3,   1,   0,   0, 0,    0};
    vecs[5]  = '{0, 0, 0,   1,  'hA,  0, 0,   0,  1,  4,   1,   0,   0, 0,    0};
    vecs[6]  = '{0, 0, 0,   1,  'hB,  0, 0,   0,  0,  4,   1,   0,   1, 'hA,  0};
    vecs[7]  = '{0, 0, 0,   0,  0,    1, 0,   0,  0,  4,   1,   0,   1, 'hA,  0};
    vecs[8]  = '{0, 0, 0,   0,  0,    0, 1,   0,  0,  4,   1,   0,   1, 'hA,  0};
    vecs[9]  = '{0, 0, 0,   0,  0,    0, 1,   0,  0,  4,   1,   0,   1, 'hB,  0};
    vecs[10] = '{0, 0, 0,   0,  0,    0, 0,   0,  0,  4,   1,   0,   0, 0,    0};
    vecs[11] = '{0, 0, 0,   0,  0,    0, 0,   0,  0,  4,   0,   1,   0, 0,    0};
    vecs[12] = '{0, 0, 0,   0,  0,    0, 0,   0,  0,  4,   0,   0,   0, 0,    0};

    idleInputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    $display("[TB] basic inference after power-on reset");
    runTable("basic");

    // Fill the FIFO, push+pop on full, then overflow one word.
    $display("[TB] result FIFO full and overflow");
    startCmd();
    feedWords(4, 32'h100);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h10 + i, 1'b0, 1'b0);
      @(negedge clk);
    end
    checkOutput("fullErr", 32'(aErr), 0);
    checkOutput("fullHead", aRes, 32'h10);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h99, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("fullPushPopErr", 32'(aErr), 0);
    checkOutput("fullPushPopHead", aRes, 32'h11);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'hEE, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("overflowErr", 32'(aErr), 1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 7; k++) expPop[k] = 32'h11 + k;
    expPop[7] = 32'h99;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput($sformatf("drainValid%0d", k), 32'(aResValid), 1);
      checkOutput($sformatf("drainData%0d", k), aRes, expPop[k]);
      @(negedge clk);
    end
    idleInputs();
    checkOutput("drainEmpty", 32'(aResValid), 0);
    checkOutput("drainBusy", 32'(aBusy), 1);
    @(negedge clk);
    checkOutput("drainDone", 32'(aDone), 1);
    checkOutput("drainErrSticky", 32'(aErr), 1);

    $display("[TB] done timeout");
    startCmd();
    feedWords(4, 32'h200);
    cyc = 0;
    while (aErr[1] == 1'b0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("timeoutCycles", cyc, 16);
    @(negedge clk);
    checkOutput("timeoutDone", 32'(aDone), 1);
    checkOutput("timeoutBusy", 32'(aBusy), 0);
    checkOutput("timeoutErr", 32'(aErr), 2);
    startCmd();
    checkOutput("restartErrClear", 32'(aErr), 0);
    checkOutput("restartBusy", 32'(aBusy), 1);

    $display("[TB] reset in the middle of SEND");
    feedWords(2, 32'h300);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h55, 1'b0, 1'b0);
    @(negedge clk);
    idleInputs();
    checkOutput("preResetValid", 32'(aResValid), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstBusy", 32'(aBusy), 0);
    checkOutput("rstInReady", 32'(aInReady), 0);
    checkOutput("rstResValid", 32'(aResValid), 0);
    checkOutput("rstNewData", 32'(aNew), 0);
    checkOutput("rstMlpData", aData, 0);
    runTable("afterReset");

    $display("[TB] start in WAIT_DONE and done in SEND are ignored");
    startCmd();
    feedWords(2, 32'h400);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    idleInputs();
    feedWords(2, 32'h402);
    checkOutput("ignLastData", aData, 32'h403);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    idleInputs();
    checkOutput("ignStartInReady", 32'(aInReady), 0);
    checkOutput("ignStartBusy", 32'(aBusy), 1);
    repeat (4) @(negedge clk);
    checkOutput("ignDoneStillWaiting", 32'(aBusy), 1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    idleInputs();
    @(negedge clk);
    checkOutput("ignFinalDone", 32'(aDone), 1);
    checkOutput("ignFinalBusy", 32'(aBusy), 0);
    checkOutput("ignFinalErr", 32'(aErr), 0);

    $display("[TB] strobe spacing with ISSUE_GAP=3");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    startCmd();
    gapRun(1'b0);
    finishB();
    startCmd();
    gapRun(1'b1);
    finishB();
    checkOutput("gapResValid", 32'(bResValid), 0);
    checkOutput("gapResData", bRes, 0);

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mlp_feeder.md
Name: mlp_feeder

Overview:
- Host-side driver for the MLP block's streaming interface.
- Accepts a start command and VECTOR_LEN input words over a valid/ready handshake, then presents each word to the MLP as data plus a one-cycle new_data strobe, with a programmable minimum spacing between strobes.
- Captures every MLP result (mlp_output qualified by output_ready) into a result FIFO drained by valid/ready.
- Tracks MLP done, with a timeout, and reports completion and errors.

Parameters:
- DATA_WIDTH, 32, width of input words driven to the MLP.
- OUTPUT_WIDTH, 32, width of MLP result words.
- VECTOR_LEN, 16, input words per inference (>=1).
- ISSUE_GAP, 1, minimum clk cycles between consecutive new_data strobes (>=1; 1 = back-to-back).
- RES_DEPTH, 8, result FIFO depth (power of 2, >=2).
- TIMEOUT, 1024, max cycles in WAIT_DONE before error.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin inference; sampled only in IDLE.
- in_data  input  DATA_WIDTH  input word from host.
- in_valid  input  1  in_data valid.
- in_ready  output  1  feeder accepts in_data this cycle.
- mlp_data  output  DATA_WIDTH  word to MLP data.
- mlp_new_data  output  1  one-cycle strobe; mlp_data valid.
- mlp_output_ready  input  1  MLP result valid this cycle.
- mlp_output  input  OUTPUT_WIDTH  MLP result word.
- mlp_done  input  1  MLP inference complete.
- res_data  output  OUTPUT_WIDTH  FIFO head.
- res_valid  output  1  FIFO non-empty.
- res_ready  input  1  host pops head.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse on return to IDLE.
- error  output  2  sticky: bit0 result overflow, bit1 done timeout.

Behaviour:
- Reset (rst=1 at a clk edge, any state): state=IDLE; all outputs 0, including mlp_data, mlp_new_data, in_ready, res_valid, busy, done and error; FIFO pointers and occupancy cleared; all counters cleared. Reset mid-inference discards all captured results.
- States: IDLE, SEND, WAIT_DONE, FLUSH.
- IDLE:
  - start=1 -> SEND; word count=0; gap counter=0; error cleared.
  - in_ready=0 in IDLE.
- SEND:
  - in_ready = (gap counter==0) && (count<VECTOR_LEN). Combinational from registered state, so no dependency on in_valid.
  - On in_valid&&in_ready: mlp_data<=in_data and mlp_new_data<=1 for exactly the next cycle; count++; gap counter loaded with ISSUE_GAP-1, decremented each cycle to 0.
  - mlp_data holds its last value between strobes.
  - After the VECTOR_LEN-th accept -> WAIT_DONE (same edge as the last strobe register); timeout counter=0.
  - Host stalls (in_valid=0) are unbounded in SEND; no timeout applies.
- WAIT_DONE:
  - Timeout counter increments each cycle.
  - mlp_done=1 -> FLUSH.
  - Counter reaching TIMEOUT-1 without done -> error[1]<=1, then FLUSH.
  - mlp_done seen in SEND is ignored (not latched).
- FLUSH: when FIFO empty -> IDLE, with done=1 for one cycle.
- Result capture:
  - Active in SEND, WAIT_DONE and FLUSH; mlp_output_ready ignored in IDLE.
  - mlp_output_ready=1 and FIFO not full: push mlp_output.
  - FIFO full: word dropped, error[0]<=1.
  - Simultaneous push and pop when full: pop frees the slot and the push succeeds, no error. Occupancy is unchanged.
  - Simultaneous push and pop when empty: push stored; res_valid rises next cycle. No bypass, so a push becomes visible one cycle later.
- FIFO:
  - res_data/res_valid reflect registered head and occupancy.
  - Pop on res_valid&&res_ready.
  - Pointers wrap modulo RES_DEPTH; occupancy counter is log2(RES_DEPTH)+1 bits.
- Error bits are sticky until the next accepted start or rst.
- start while busy is ignored.
- Latency: in_data accepted at edge N appears on mlp_data with mlp_new_data=1 during cycle N+1.

Test Plan:
- VECTOR_LEN=4, ISSUE_GAP=1, in_valid held high with words 1,2,3,4 -> 4 consecutive strobes with mlp_data=1,2,3,4. MLP model then returns 2 results 0xA,0xB, then done -> res pops 0xA,0xB, done pulse, error=0.
- ISSUE_GAP=3 -> in_ready high 1 cycle in every 3; strobes spaced exactly 3 cycles apart; in_valid toggling randomly never yields a strobe closer than 3 cycles.
- RES_DEPTH=8, res_ready=0, MLP emits 9 results -> FIFO holds the first 8, the 9th is dropped, error=01. On a full FIFO with res_ready=1, a simultaneous push still succeeds with no error.
- Never assert mlp_done, TIMEOUT=16 -> error[1] set 16 cycles after entering WAIT_DONE; FLUSH drains, then done pulse. A following start clears error to 00.
- Assert rst in SEND after 2 of 4 words -> next cycle busy=0, in_ready=0, res_valid=0, mlp_new_data=0. A new start runs a full clean inference.
- start pulsed during WAIT_DONE -> ignored, no count reset; mlp_done pulsed during SEND -> ignored, and the feeder still waits for a done in WAIT_DONE.
